key_pulser: RTL and testbench
=============================

# key_pulser

Front end that feeds the one-cycle command strobes (start, stop, show) into the random-number Top from the board's active-low push-buttons. Each of N channels synchronizes a raw KEY input, debounces it with a per-channel counter, and emits one clock-wide pulse per accepted press plus a clean debounced level. It sits between the board pins and Top in the FPGA wrapper.

## Interface
- N_KEYS, 3: number of independent key channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥ 1.
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_key_n  input  N_KEYS  raw button levels; 0 = pressed; asynchronous to i_clk.
- o_pulse  output  N_KEYS  one-cycle high strobe per accepted press.
- o_level  output  N_KEYS  debounced level; 1 = pressed.

## Operation
- Per channel: 2-FF synchronizer → sample s; debounce FSM with counter of width $clog2(DEBOUNCE_CYCLES+1).
- FSM states:
  - RELEASED: o_level=0. s==0 (pressed) → PRESS_CNT, counter=1.
  - PRESS_CNT: s==0 → counter+1; counter reaching DEBOUNCE_CYCLES → HELD with o_pulse=1 for that cycle. s==1 → RELEASED, counter=0.
  - HELD: o_level=1. s==1 → RELEASE_CNT, counter=1.
  - RELEASE_CNT: s==1 → counter+1; reaching DEBOUNCE_CYCLES → RELEASED (no pulse). s==0 → HELD, counter=0.
- A bounce shorter than DEBOUNCE_CYCLES aborts the count; no pulse, no level change.
- DEBOUNCE_CYCLES=1: PRESS_CNT is entered and left in consecutive cycles; pulse still exactly one cycle.
- Exactly one pulse per press regardless of hold duration; no auto-repeat.
- Channels fully independent; simultaneous presses on several keys pulse in the same cycle if their edges are synchronized in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES; no wrap.

## Timing
- Reset (async assert, sync release via normal flops): synchronizer flops = 1 (released), FSM = RELEASED, counter = 0, o_pulse = 0, o_level = 0.
- Latency: if i_key_n is first sampled low at edge k and stays low, o_pulse is high for the cycle following edge k+2+DEBOUNCE_CYCLES−1 … precisely: synchronizer output low after edge k+1, o_pulse and o_level rise after edge k+1+DEBOUNCE_CYCLES; o_pulse falls on the next edge.
- Release latency identical: o_level falls DEBOUNCE_CYCLES+1 edges after the first released sample.
- o_pulse and o_level are registered outputs (no combinational path from i_key_n).
- Key held through reset release: treated as a new press; pulse issued after normal latency.
- Reset mid-count or mid-pulse: pulse and level drop immediately; count discarded.
- Minimum press-to-press spacing for two pulses: 2×DEBOUNCE_CYCLES cycles stable in alternating levels.

## Structure
- Package key_pulser_pkg: state enum (RELEASED, PRESS_CNT, HELD, RELEASE_CNT), and a function for counter width.
- Sub-module key_debounce_ch: single channel (synchronizer + FSM + counter), DEBOUNCE_CYCLES parameter; key_pulser instantiates N_KEYS copies in a generate loop.

## Test plan
All with N_KEYS=3, DEBOUNCE_CYCLES=4.
- Reset then idle keys (all 1) for 50 cycles → o_pulse=000, o_level=000 throughout.
- Key0 low at edge k, held 20 cycles → o_pulse[0] high for exactly one cycle after edge k+5, o_level[0] high from then until 5 edges after release; no second pulse.
- Key1 bounce: low 3 cycles, high 1, low 3, high → no pulse, o_level[1] stays 0.
- Key0 and key2 pressed on the same edge → o_pulse=101 in one cycle; key1 pressed 2 cycles later → o_pulse=010 two cycles after that.
- Release bounce on held key2 (high 2, low 1, high 10) → o_level[2] stays 1 until 5 edges after final rise; no extra pulse.
- i_rst_n asserted while key0 in PRESS_CNT (count 3) and key1 HELD → outputs 0 immediately; key1 still held after release → one pulse on key1 after 5 edges, none on key0 if released.

Source files
------------

// File: rtl/key_pulser_pkg.sv
// Shared types and helpers for the push-button front end.
package key_pulser_pkg;

  // Debounce FSM states for one key channel.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CNT   = 2'd1,
    HELD        = 2'd2,
    RELEASE_CNT = 2'd3
  } key_state_t;

  // Counter width able to hold values 0..cycles.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchronizer, debounce FSM with stability counter,
// one-cycle press strobe and clean debounced level.
module key_debounce_ch
  import key_pulser_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  // Count value at which the next stable cycle completes the debounce window.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;

  // Bring the asynchronous key level into the clock domain; reset as released.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_key_n};
    end
  end

  assign s = sync_q[1];

  // Debounce FSM: a level change is accepted only after an unbroken run of
  // DEBOUNCE_CYCLES samples; any opposite sample aborts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= RELEASED;
      cnt     <= '0;
      o_pulse <= 1'b0;
      o_level <= 1'b0;
    end else begin
      o_pulse <= 1'b0;
      case (state)
        RELEASED: begin
          if (!s) begin
            state <= PRESS_CNT;
            cnt   <= CW'(1);
          end
        end
        PRESS_CNT: begin
          if (s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            o_pulse <= 1'b1;
            o_level <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (s) begin
            state <= RELEASE_CNT;
            cnt   <= CW'(1);
          end
        end
        RELEASE_CNT: begin
          if (!s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state   <= RELEASED;
            cnt     <= '0;
            o_level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= RELEASED;
          cnt     <= '0;
          o_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_pulser.sv
// N independent debounced key channels producing press strobes and levels.
module key_pulser
  import key_pulser_pkg::*;
#(
  parameter int unsigned N_KEYS          = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_pulse,
  output logic [N_KEYS-1:0] o_level
);

  // One fully independent debounce channel per key.
  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_key_n(i_key_n[g]),
      .o_pulse(o_pulse[g]),
      .o_level(o_level[g])
    );
  end

endmodule

// File: tb/tb_key_pulser.sv
// Scoreboard bench for key_pulser with N_KEYS=3, DEBOUNCE_CYCLES=4.
module tb_key_pulser;

  localparam int unsigned NK = 3;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] pulse;
  logic [NK-1:0] level;

  typedef struct {
    int         cyc;
    logic [2:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_pass = 0;
  int   n_chk  = 0;

  key_pulser #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_key_n(key_n),
    .o_pulse(pulse),
    .o_level(level)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Monitor: each visible pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("pulse_missing", 0, int'(sb[0].vec));
      void'(sb.pop_front());
    end
    if (pulse != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(pulse), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_vec", int'(pulse), int'(e.vec));
        chk("pulse_cyc", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int k, k0, r, f;
    rst_n = 1'b0;
    key_n = 3'b111;
    #1;
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_level", int'(level), 0);
    step(2);
    rst_n = 1'b1;

    // Idle keys: nothing happens.
    for (int i = 0; i < 5; i++) begin
      step(10);
      chk("idle_level", int'(level), 0);
    end

    // Key0 single press held 20 cycles.
    step(1);
    k = cyc + 1;
    key_n[0] = 1'b0;
    sb.push_back('{k + 5, 3'b001});
    wait_to(k + 4);
    chk("k0_level_pre", int'(level[0]), 0);
    wait_to(k + 5);
    chk("k0_level_rise", int'(level[0]), 1);
    wait_to(k + 19);
    key_n[0] = 1'b1;
    r = cyc + 1;
    wait_to(r + 4);
    chk("k0_level_hold", int'(level[0]), 1);
    wait_to(r + 5);
    chk("k0_level_fall", int'(level[0]), 0);
    step(5);

    // Key1 bounce: low 3, high 1, low 3, high.
    key_n[1] = 1'b0;
    step(3);
    key_n[1] = 1'b1;
    step(1);
    key_n[1] = 1'b0;
    step(2);
    chk("k1_bounce_mid", int'(level[1]), 0);
    step(1);
    key_n[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(3);
      chk("k1_bounce_level", int'(level), 0);
    end

    // Key0+key2 together, key1 two cycles later.
    step(1);
    k = cyc + 1;
    key_n = 3'b010;
    sb.push_back('{k + 5, 3'b101});
    wait_to(k + 1);
    key_n[1] = 1'b0;
    sb.push_back('{k + 7, 3'b010});
    wait_to(k + 10);
    chk("multi_level", int'(level), 7);
    key_n = 3'b011;
    r = cyc + 1;
    wait_to(r + 6);
    chk("multi_release", int'(level), 4);

    // Release bounce on held key2: high 2, low 1, high.
    key_n[2] = 1'b1;
    r = cyc + 1;
    step(2);
    key_n[2] = 1'b0;
    step(1);
    key_n[2] = 1'b1;
    f = r + 3;
    wait_to(f + 4);
    chk("k2_rel_hold", int'(level[2]), 1);
    wait_to(f + 5);
    chk("k2_rel_fall", int'(level[2]), 0);
    step(8);

    // Reset while key0 counts and key1 is held.
    k = cyc + 1;
    key_n[1] = 1'b0;
    sb.push_back('{k + 5, 3'b010});
    wait_to(k + 7);
    chk("pre_rst_level", int'(level), 2);
    k0 = cyc + 1;
    key_n[0] = 1'b0;
    wait_to(k0 + 4);
    rst_n = 1'b0;
    key_n[0] = 1'b1;
    #1;
    chk("midrst_pulse", int'(pulse), 0);
    chk("midrst_level", int'(level), 0);
    step(2);
    rst_n = 1'b1;
    k = cyc + 1;
    sb.push_back('{k + 5, 3'b010});
    wait_to(k + 4);
    chk("post_rst_pre", int'(level), 0);
    wait_to(k + 5);
    chk("post_rst_level", int'(level), 2);
    key_n[1] = 1'b1;
    step(12);
    chk("final_level", int'(level), 0);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
